// File: rtl/execution_driver_if.sv
// Program-memory fetch bus between the execution driver (master) and program memory (slave).
interface execution_driver_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int OPCODE_SIZE = 8
);
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [OPCODE_SIZE-1:0] mem_data;
  logic                   mem_valid;

  modport master (output mem_req, mem_addr, input  mem_data, mem_valid);
  modport slave  (input  mem_req, mem_addr, output mem_data, mem_valid);
endinterface

// File: rtl/execution_driver.sv
// Fetch/decode/execute sequencer with start/resume and single-step from the halted state.
module execution_driver #(
  parameter int ADDR_WIDTH  = 8,
  parameter int OPCODE_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   step,
  input  logic                   run_enable,
  execution_driver_if.master     bus,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   exec_strobe,
  output logic                   running,
  output logic                   halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALTED
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [OPCODE_SIZE-1:0] opcode_q;
  logic                   step_mode_q;
  logic                   mem_req_q;
  logic                   exec_strobe_q;
  logic                   running_q;
  logic                   halted_q;

  // Wraps modulo 2^ADDR_WIDTH by truncation.
  always_comb pc_d = pc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      opcode_q      <= '0;
      step_mode_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      exec_strobe_q <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      exec_strobe_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q      <= '0;
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
            running_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_req_q && bus.mem_valid) begin
            opcode_q  <= bus.mem_data;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q       <= S_EXECUTE;
          exec_strobe_q <= 1'b1;
        end
        S_EXECUTE: begin
          // A halt leaves pc on the halt instruction; otherwise advance.
          if (!run_enable || step_mode_q) begin
            state_q     <= S_HALTED;
            halted_q    <= 1'b1;
            running_q   <= 1'b0;
            step_mode_q <= 1'b0;
            if (run_enable) pc_q <= pc_d;
          end else begin
            pc_q      <= pc_d;
            state_q   <= S_FETCH;
            mem_req_q <= 1'b1;
          end
        end
        S_HALTED: begin
          if (start || step) begin
            pc_q        <= pc_d;
            state_q     <= S_FETCH;
            mem_req_q   <= 1'b1;
            running_q   <= 1'b1;
            halted_q    <= 1'b0;
            step_mode_q <= !start;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc_q;
  assign opcode       = opcode_q;
  assign exec_strobe  = exec_strobe_q;
  assign running      = running_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_execution_driver.sv
// Randomized scoreboard bench for execution_driver with a program-memory responder and halt_check model.
module tb_execution_driver;
  localparam int AW = 8;
  localparam int OW = 8;
  localparam logic [OW-1:0] HALT_OP = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic step = 1'b0;
  logic run_enable;
  logic [OW-1:0] opcode;
  logic exec_strobe, running, halted;

  execution_driver_if #(.ADDR_WIDTH(AW), .OPCODE_SIZE(OW)) bus ();

  execution_driver #(.ADDR_WIDTH(AW), .OPCODE_SIZE(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .run_enable(run_enable),
    .bus(bus.master), .opcode(opcode), .exec_strobe(exec_strobe),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  // halt_check: only the halt opcode stops execution.
  assign run_enable = (opcode != HALT_OP);

  logic [OW-1:0] mem [256];
  int unsigned   dly [256];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  typedef struct { logic [AW-1:0] addr; logic [OW-1:0] op; int when; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [AW-1:0] m_pc = '0;
  bit            m_idle = 1'b1;
  bit            m_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: answers after dly[addr] cycles, babbles when no request is pending.
  int unsigned wcnt = 0;
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
  end
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wcnt == dly[bus.mem_addr]) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = mem[bus.mem_addr];
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = OW'($urandom);
      end
      wcnt++;
    end else begin
      wcnt = 0;
      bus.mem_valid = ($urandom_range(3) == 0);
      bus.mem_data  = OW'($urandom);
    end
  end

  // Monitor: every execute strobe must match the next predicted instruction.
  always @(negedge clk) begin
    if (rst_n && exec_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("exec_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("exec_opcode", 32'(opcode), 32'(e.op));
        check("exec_cycle", 32'(cyc), 32'(e.when));
      end
    end
  end

  // Instruction-level model: run from pc until a halt opcode (or one instruction when single).
  task automatic model_run(input logic [AW-1:0] pc0, input bit single, input int e0);
    logic [AW-1:0] p;
    int t;
    exp_t e;
    p = pc0;
    t = e0;
    forever begin
      e.addr = p;
      e.op   = mem[p];
      e.when = t + int'(dly[p]) + 2;
      exp_q.push_back(e);
      if (mem[p] == HALT_OP) break;
      p = p + 1'b1;
      t = e.when + 1;
      if (single) break;
    end
    m_pc = p;
    m_idle = 1'b0;
    m_halted = 1'b1;
  endtask

  // Drive a one-cycle command pulse and predict its effect; returns whether execution starts.
  task automatic issue(input bit s, input bit st, output bit active);
    int e0;
    @(negedge clk);
    start = s;
    step  = st;
    e0 = cyc + 1;
    active = 1'b0;
    if (m_idle && s) begin
      model_run('0, 1'b0, e0);
      active = 1'b1;
    end else if (m_halted && (s || st)) begin
      model_run(m_pc + 1'b1, !s, e0);
      active = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
  endtask

  task automatic finish_cmd(input bit active, input bit noise);
    int n;
    n = 0;
    if (active) begin
      while (!halted && n < 4000) begin
        if (noise && running) begin
          start = ($urandom_range(7) == 0);
          step  = ($urandom_range(7) == 0);
        end
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      step  = 1'b0;
    end else begin
      repeat (5) @(negedge clk);
    end
    check("halted", 32'(halted), 32'(m_halted));
    check("running", 32'(running), 32'd0);
    check("pc", 32'(bus.mem_addr), 32'(m_pc));
    check("pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_cmd(input bit s, input bit st, input bit noise);
    bit a;
    issue(s, st, a);
    finish_cmd(a, noise);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = '0;
    m_idle = 1'b1;
    m_halted = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      dly[i] = 0;
    end
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = HALT_OP; mem[3] = 8'h30; mem[5] = HALT_OP;

    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_strobe", 32'(exec_strobe), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;

    do_cmd(1'b0, 1'b1, 1'b0);  // step in IDLE is ignored
    do_cmd(1'b1, 1'b0, 1'b0);  // zero-stall program runs to the halt at 2
    do_cmd(1'b0, 1'b1, 1'b0);  // single step executes 0x30 at 3, halts at pc 4
    do_cmd(1'b1, 1'b0, 1'b0);  // resume from 5: halts immediately there

    sync_reset();
    for (int i = 0; i < 256; i++) dly[i] = 2;
    do_cmd(1'b1, 1'b0, 1'b0);  // two-cycle memory stalls
    mem[3] = 8'h44; mem[4] = 8'h55;
    do_cmd(1'b1, 1'b1, 1'b0);  // start beats step: runs through to the halt at 5

    // Asynchronous reset while a fetch is outstanding.
    for (int i = 0; i < 256; i++) dly[i] = 3;
    mem[6] = 8'h66; mem[7] = HALT_OP;
    issue(1'b1, 1'b0, a);
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    check("fetch_pending", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_req", 32'(bus.mem_req), 32'd0);
    check("async_running", 32'(running), 32'd0);
    check("async_pc", 32'(bus.mem_addr), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1'b0, 1'b1, 1'b0);
    do_cmd(1'b1, 1'b0, 1'b0);  // restarts from address 0

    // Random programs, stalls and commands, with ignored pulses injected while running.
    for (int r = 0; r < 60; r++) begin
      if (r % 15 == 0) begin
        for (int i = 0; i < 256; i++) begin
          mem[i] = ($urandom_range(5) == 0) ? HALT_OP : OW'($urandom);
          dly[i] = $urandom_range(3);
        end
        mem[$urandom_range(255)] = HALT_OP;
      end
      case ($urandom_range(3))
        0: do_cmd(1'b1, 1'b0, 1'b1);
        1: do_cmd(1'b0, 1'b1, 1'b1);
        2: do_cmd(1'b1, 1'b1, 1'b1);
        default: do_cmd(1'b0, 1'b1, 1'b0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
